// File: rtl/wisc_mem_pkg.sv
// wisc_mem_pkg: shared state type and constants for the memory-stage controller
package wisc_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int DATA_W_DEFAULT = 16;
  localparam logic [15:0] FAULT_DATA = 16'hDEAD;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts enabled cycles and flags the enabled cycle that completes TIMEOUT counts
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear dominates counting; expiry fires on the TIMEOUT-th enabled cycle
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    expire = en & (cnt_q == CW'(TIMEOUT - 1));
  end
  // counter register
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage req/ack controller feeding MEM/WB; MEM_TIMEOUT_EN adds a WAIT timeout fault
module mem_stage_ctrl
  import wisc_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_ret,
  input  logic              ex_mem_to_reg,
  input  logic [3:0]        ex_reg_rd,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] mem_read_data,
  output logic [3:0]        reg_rd,
  output logic              ret,
  output logic              mem_to_reg,
  output logic [DATA_W-1:0] alu_result,
  output logic              stall,
  output logic              mem_fault
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic              we_q, we_d, fault_q, fault_d;
  logic              op, in_wait, expire;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT must be at least 1");
  end
  assign op            = ex_mem_read | ex_mem_write | ex_ret;
  assign in_wait       = state_q == WAIT;
  assign reg_rd        = ex_reg_rd;
  assign ret           = ex_ret;
  assign mem_to_reg    = ex_mem_to_reg;
  assign alu_result    = ex_alu_result;
  assign dmem_req      = in_wait;
  assign dmem_we       = in_wait & we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign mem_read_data = rdata_q;
  assign mem_fault     = fault_q;
  assign stall         = in_wait | (state_q == IDLE & op);
`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (~in_wait),
    .en     (in_wait),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif
  // accept an op in IDLE, finish on ack (ack beats timeout), then one DONE cycle for MEM/WB capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    if (state_q == IDLE && op) begin
      state_d = WAIT;
      addr_d  = ex_addr;
      wdata_d = ex_wdata;
      we_d    = ex_mem_write & ~ex_mem_read & ~ex_ret;
    end else if (in_wait && (dmem_ack || expire)) begin
      state_d = DONE;
      rdata_d = dmem_ack ? (we_q ? rdata_q : dmem_rdata) : DATA_W'(FAULT_DATA);
      fault_d = ~dmem_ack;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: transaction-timeline model of the MEM stage with directed and random ops
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 15;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_mem_read = 0, ex_mem_write = 0, ex_ret = 0, ex_mem_to_reg = 0;
  logic [3:0]  ex_reg_rd = '0;
  logic [15:0] ex_addr = '0, ex_wdata = '0, ex_alu_result = '0;
  logic        dmem_ack = 0;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_req, dmem_we, ret, mem_to_reg, stall, mem_fault;
  logic [15:0] dmem_addr, dmem_wdata, mem_read_data, alu_result;
  logic [3:0]  reg_rd;

  mem_stage_ctrl #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_ret(ex_ret), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_rd(ex_reg_rd),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu_result(ex_alu_result),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .mem_read_data(mem_read_data),
    .reg_rd(reg_rd), .ret(ret), .mem_to_reg(mem_to_reg), .alu_result(alu_result),
    .stall(stall), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, stall_seen = 0, fault_seen = 0;
  logic chk_en = 1'b0;
  logic exp_stall = 0, exp_req = 0, exp_we = 0, exp_fault = 0;
  logic [15:0] m_rdata = '0, m_addr = '0, m_wdata = '0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (chk_en) begin
      cmp("stall", stall, exp_stall);
      cmp("dmem_req", dmem_req, exp_req);
      if (exp_req) cmp("dmem_we", dmem_we, exp_we);
      cmp("dmem_addr", dmem_addr, m_addr);
      cmp("dmem_wdata", dmem_wdata, m_wdata);
      cmp("mem_read_data", mem_read_data, m_rdata);
      cmp("mem_fault", mem_fault, exp_fault);
      cmp("reg_rd", reg_rd, ex_reg_rd);
      cmp("ret", ret, ex_ret);
      cmp("mem_to_reg", mem_to_reg, ex_mem_to_reg);
      cmp("alu_result", alu_result, ex_alu_result);
      if (stall) stall_seen++;
      if (mem_fault) fault_seen++;
    end

  // one instruction through MEM; k = WAIT cycle carrying ack, k = 0 means no ack ever
  task automatic do_op(input logic rd, input logic wr, input logic rt, input logic m2r,
                       input logic [3:0] r, input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] alu, input int k, input logic [15:0] rdat);
    logic isw;
    bit tmo;
    int nw;
    isw = wr & ~rd & ~rt;
    tmo = TO_EN && (k == 0 || k > TIMEOUT);
    nw = tmo ? TIMEOUT : k;
    ex_mem_read = rd; ex_mem_write = wr; ex_ret = rt; ex_mem_to_reg = m2r;
    ex_reg_rd = r; ex_addr = a; ex_wdata = wd; ex_alu_result = alu;
    dmem_ack = 1'($urandom); dmem_rdata = 16'($urandom);
    exp_req = 0; exp_we = 0; exp_fault = 0; exp_stall = rd | wr | rt;
    step();
    if (!(rd | wr | rt)) return;
    m_addr = a;
    m_wdata = wd;
    for (int i = 1; i <= nw; i++) begin
      exp_req = 1; exp_we = isw; exp_stall = 1;
      dmem_ack = !tmo && i == k;
      dmem_rdata = (i == k) ? rdat : 16'($urandom);
      step();
    end
    if (tmo) m_rdata = 16'hDEAD;
    else if (!isw) m_rdata = rdat;
    exp_req = 0; exp_we = 0; exp_stall = 0; exp_fault = tmo;
    dmem_ack = 1'($urandom); dmem_rdata = 16'($urandom);
    step();
    exp_fault = 0;
  endtask

  initial begin
    int kind, k;
    step();
    chk_en = 1;
    step();
    rst = 0;
    step();
    stall_seen = 0;
    do_op(1, 0, 0, 1, 4'h3, 16'h0040, 16'h0000, 16'h0040, 2, 16'h1234);
    cmp("load_rdata", mem_read_data, 16'h1234);
    cmp("load_stall_cycles", 16'(stall_seen), 16'd3);
    stall_seen = 0;
    do_op(0, 1, 0, 0, 4'h0, 16'h0010, 16'hBEEF, 16'h0010, 1, 16'h7777);
    cmp("store_wdata", dmem_wdata, 16'hBEEF);
    cmp("store_addr", dmem_addr, 16'h0010);
    cmp("store_rdata_held", mem_read_data, 16'h1234);
    cmp("store_stall_cycles", 16'(stall_seen), 16'd2);
    stall_seen = 0;
    do_op(0, 0, 0, 0, 4'h5, 16'h0000, 16'h0000, 16'h00AA, 1, 16'h0000);
    cmp("alu_no_stall", 16'(stall_seen), 16'd0);
    cmp("alu_reg_rd", reg_rd, 16'h0005);
    cmp("alu_result_pass", alu_result, 16'h00AA);
    do_op(0, 0, 1, 1, 4'h7, 16'hFFFE, 16'h0000, 16'hFFFE, 3, 16'h0300);
    cmp("ret_flag", ret, 16'h0001);
    cmp("ret_rdata", mem_read_data, 16'h0300);
    ex_mem_read = 1; ex_addr = 16'h0080; dmem_ack = 0;
    exp_stall = 1;
    step();
    m_addr = 16'h0080;
    exp_req = 1; exp_we = 0;
    step();
    step();
    chk_en = 0;
    rst = 1;
    step();
    rst = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_ret = 0;
    dmem_ack = 1; dmem_rdata = 16'h5555;
    m_rdata = '0; m_addr = '0; m_wdata = '0;
    exp_req = 0; exp_we = 0; exp_stall = 0; exp_fault = 0;
    chk_en = 1;
    step();
    step();
    cmp("rst_rdata_clear", mem_read_data, 16'h0000);
    cmp("rst_req_low", dmem_req, 16'h0000);
    dmem_ack = 0;
`ifdef MEM_TIMEOUT_EN
    stall_seen = 0; fault_seen = 0;
    do_op(1, 0, 0, 1, 4'h2, 16'h0100, 16'h0000, 16'h0100, 0, 16'h0000);
    cmp("timeout_fault_pulses", 16'(fault_seen), 16'd1);
    cmp("timeout_rdata", mem_read_data, 16'hDEAD);
    cmp("timeout_stall_cycles", 16'(stall_seen), 16'd16);
    stall_seen = 0; fault_seen = 0;
    do_op(1, 0, 0, 1, 4'h2, 16'h0102, 16'h0000, 16'h0102, 15, 16'h4242);
    cmp("late_ack_no_fault", 16'(fault_seen), 16'd0);
    cmp("late_ack_rdata", mem_read_data, 16'h4242);
    cmp("late_ack_stall_cycles", 16'(stall_seen), 16'd16);
`endif
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 4);
      k = $urandom_range(1, 5);
      if (TO_EN && $urandom_range(0, 9) == 0) k = $urandom_range(0, 1) ? 0 : TIMEOUT;
      do_op(kind == 1 || kind == 4, kind == 2 || kind == 4, kind == 3, 1'($urandom),
            4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), k, 16'($urandom));
    end
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller of the 5-stage 16-bit pipeline: producer side of the MEM/WB interface.
- Takes EX/MEM control and data, runs a req/ack handshake to data memory, and presents the memory read data and pass-through fields that MEM/WB latches.
- Stalls the front of the pipeline until the memory read data is valid for MEM/WB to capture.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 15, max WAIT cycles before fault (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- ex_mem_read  in  1  load in MEM stage.
- ex_mem_write  in  1  store in MEM stage.
- ex_ret  in  1  ret: stack read, treated as load.
- ex_mem_to_reg  in  1  WB source select, passed through.
- ex_reg_rd  in  4  destination register, passed through.
- ex_addr  in  DATA_W  memory address (ALU result).
- ex_wdata  in  DATA_W  store data.
- ex_alu_result  in  DATA_W  passed through.
- dmem_ack  in  1  memory completion; qualifies dmem_rdata.
- dmem_rdata  in  DATA_W  memory read data.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  write enable, valid with dmem_req.
- dmem_addr  out  DATA_W  registered address.
- dmem_wdata  out  DATA_W  registered store data.
- mem_read_data  out  DATA_W  to MEM/WB mem_read_data_in.
- reg_rd  out  4  to MEM/WB reg_rd_in.
- ret  out  1  to MEM/WB ret_in.
- mem_to_reg  out  1  to MEM/WB mem_to_reg_in.
- alu_result  out  DATA_W  to MEM/WB alu_result_in.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB captures when low.
- mem_fault  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, mem_fault = 0; dmem_addr, dmem_wdata, mem_read_data = 0; timeout counter = 0. Reset mid-transaction abandons it; ack after reset is ignored.
- reg_rd, ret, mem_to_reg, alu_result: combinational pass-through of ex_* (EX/MEM holds them while stalled).
- op = ex_mem_read | ex_mem_write | ex_ret.
- IDLE:
  - op = 0: stall = 0, no request.
  - op = 1: stall = 1; latch ex_addr, ex_wdata, and we = ex_mem_write & ~ex_mem_read & ~ex_ret; next state WAIT.
- WAIT:
  - dmem_req = 1, stall = 1, counter increments each cycle.
  - On dmem_ack: for a read, mem_read_data <= dmem_rdata; for a write, it holds. dmem_req drops next cycle; next state DONE.
- DONE:
  - stall = 0; MEM/WB captures at the end of this cycle; next state IDLE. ack in IDLE or DONE is ignored.
- Latency: memory op with ack on the k-th WAIT cycle (k ≥ 1) holds the instruction in MEM for k+2 cycles, with stall high for k+1 of them. Non-memory ops take 1 cycle.
- Back-to-back memory ops: the second is accepted in the IDLE cycle after DONE.
- ex_mem_read and ex_mem_write both set: treated as a read (we = 0).
- mem_read_data holds its last value between reads.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - In WAIT, if the counter reaches TIMEOUT with no ack, go to DONE with mem_read_data <= 16'hDEAD, mem_fault = 1 for the DONE cycle, and dmem_req dropped.
  - ack in the same cycle as the timeout wins: normal completion, no fault.
- Not defined: WAIT lasts indefinitely; mem_fault tied 0; counter absent.

Decomposition:
- Package wisc_mem_pkg:
  - state enum {IDLE, WAIT, DONE};
  - DATA_W default;
  - FAULT_DATA = 16'hDEAD.
- One natural sub-module: mem_timeout_ctr (clear/enable/expire counter), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Load addr 0x0040, ack on 2nd WAIT cycle with rdata 0x1234 -> stall high 3 cycles; mem_read_data = 0x1234 in DONE; dmem_we = 0.
- Store addr 0x0010, wdata 0xBEEF, ack on 1st WAIT cycle -> dmem_we = 1, dmem_wdata = 0xBEEF; stall high 2 cycles; mem_read_data unchanged.
- ALU op only (op = 0) with reg_rd = 4'h5, alu_result = 0x00AA -> stall never asserted; outputs equal inputs same cycle.
- ret with stack data 0x0300 -> ret = 1, mem_read_data = 0x0300 in DONE.
- rst in WAIT, then a late ack -> IDLE, dmem_req = 0, mem_read_data = 0; late ack ignored.
- MEM_TIMEOUT_EN, no ack -> after 15 WAIT cycles: DONE, mem_fault pulse, mem_read_data = 0xDEAD. Repeat with ack on the 15th WAIT cycle -> no fault.
